// File: rtl/rpn_wnn_pkg.sv
// ---------------------------------------------------------------------------
// rpn_wnn_pkg
// Shared types for the WNN ingress path from the network bridge.
//   - AXIS field widths of the network-bridge stream
//   - ingress_state_t : packet-boundary FSM state of the ingress stage
//   - axis_nb_beat_t  : one AXIS beat (data, keep, id, dest, user, last)
//   - msg_type_legal(): unsigned compare of a message type against the
//                       highest legal type (types 0..type_last are legal)
// ---------------------------------------------------------------------------
package rpn_wnn_pkg;

   localparam int AXIS_DATA_WIDTH          = 512;
   localparam int AXIS_KEEP_WIDTH          = 64;
   localparam int AXIS_FROM_NB_TDEST_WIDTH = 16;
   localparam int AXIS_FROM_NB_TUSER_WIDTH = 16;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } ingress_state_t;

   typedef struct packed {
      logic [AXIS_DATA_WIDTH-1:0]          data;
      logic [AXIS_KEEP_WIDTH-1:0]          keep;
      logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] id;
      logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] dest;
      logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] user;
      logic                                last;
   } axis_nb_beat_t;

   localparam int AXIS_NB_BEAT_WIDTH = $bits(axis_nb_beat_t);

   // Both operands are zero-extended by the caller, so this is an unsigned
   // compare regardless of the configured type-field width.
   function automatic logic msg_type_legal(input logic [31:0] msg_type,
                                           input logic [31:0] type_last);
      return (msg_type <= type_last);
   endfunction

endpackage

// File: rtl/rpn_wnn_axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// rpn_wnn_axis_skid_buffer
// Generic 2-entry AXIS register slice (main + skid register).
//   - 1-cycle latency, 1 beat/cycle when out_ready is held high
//   - in_ready is registered: high when the skid register is empty
//   - out_valid/out_data hold steady while out_ready is low
// Ports
//   i_clk, i_ap_rst_n     clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data payload
// ---------------------------------------------------------------------------
module rpn_wnn_axis_skid_buffer
   import rpn_wnn_pkg::*;
#(
   parameter int WIDTH = AXIS_NB_BEAT_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_ap_rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   logic             main_valid;
   logic             skid_valid;
   logic             ready_q;
   logic [WIDTH-1:0] main_data;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             main_load;
   logic             skid_valid_nxt;

   // ready_q mirrors ~skid_valid (except in reset), so a push can never
   // coincide with an occupied skid register.
   assign push      = in_valid & ready_q;
   assign main_load = ~main_valid | out_ready;

   always_comb begin
      skid_valid_nxt = skid_valid;
      if (main_load) begin
         skid_valid_nxt = 1'b0;
      end else if (push) begin
         skid_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_ap_rst_n) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b0;
         main_data  <= '0;
         skid_data  <= '0;
      end else begin
         ready_q    <= ~skid_valid_nxt;
         skid_valid <= skid_valid_nxt;
         if (main_load) begin
            if (skid_valid) begin
               main_valid <= 1'b1;
               main_data  <= skid_data;
            end else begin
               main_valid <= push;
               if (push) begin
                  main_data <= in_data;
               end
            end
         end else if (push) begin
            skid_data <= in_data;
         end
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: rtl/rpn_wnn_from_network_bridge_ingress.sv
// ---------------------------------------------------------------------------
// rpn_wnn_from_network_bridge_ingress
// Ingress stage between the network-bridge AXIS output and the WNN
// repo/node splitter. Checks the message type (tdata low bits) on the first
// beat of each packet; legal packets pass unchanged through a 2-entry skid
// buffer, illegal packets are consumed whole and never reach the splitter.
//
// Optional feature macro: RPN_WNN_INGRESS_DROP_CNT_EN
//   defined   : o_drop_cnt counts dropped packets, saturating at all-ones
//   undefined : o_drop_cnt tied to 0, no counter built
//
// Ports
//   i_clk, i_ap_rst_n            clock, synchronous active-low reset
//   from_network_bridge_t*       AXIS slave (tready is an output)
//   to_splitter_t*               AXIS master (tready is an input)
//   o_drop_pulse                 1-cycle pulse per dropped packet header
//   o_drop_cnt                   dropped-packet count
//
// FSM states
//   state | meaning
//   HDR   | next accepted beat is a packet header; its type is checked
//   PASS  | inside a legal packet; beats go to the skid buffer
//   DROP  | inside an illegal packet; beats are accepted and discarded
// ---------------------------------------------------------------------------
module rpn_wnn_from_network_bridge_ingress
   import rpn_wnn_pkg::*;
#(
   parameter int RPN_MSG_TYPE_WIDTH = 8,
   parameter int RPN_MSG_TYPE_LAST  = 7,
   parameter int DROP_CNT_WIDTH     = 16
) (
   input  logic                                i_clk,
   input  logic                                i_ap_rst_n,

   input  logic                                from_network_bridge_tvalid,
   output logic                                from_network_bridge_tready,
   input  logic [AXIS_DATA_WIDTH-1:0]          from_network_bridge_tdata,
   input  logic [AXIS_KEEP_WIDTH-1:0]          from_network_bridge_tkeep,
   input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tid,
   input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_network_bridge_tdest,
   input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_network_bridge_tuser,
   input  logic                                from_network_bridge_tlast,

   output logic                                to_splitter_tvalid,
   input  logic                                to_splitter_tready,
   output logic [AXIS_DATA_WIDTH-1:0]          to_splitter_tdata,
   output logic [AXIS_KEEP_WIDTH-1:0]          to_splitter_tkeep,
   output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_splitter_tid,
   output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_splitter_tdest,
   output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_splitter_tuser,
   output logic                                to_splitter_tlast,

   output logic                                o_drop_pulse,
   output logic [DROP_CNT_WIDTH-1:0]           o_drop_cnt
);

   ingress_state_t                state;
   logic                          drop_pulse_q;
   logic [RPN_MSG_TYPE_WIDTH-1:0] msg_type;
   logic                          hdr_legal;
   logic                          in_fire;
   logic                          fwd;
   logic                          drop_evt;
   logic                          buf_in_ready;
   logic                          buf_out_valid;
   axis_nb_beat_t                 in_beat;
   axis_nb_beat_t                 out_beat;

   assign msg_type  = from_network_bridge_tdata[RPN_MSG_TYPE_WIDTH-1:0];
   assign hdr_legal = msg_type_legal(32'(msg_type), 32'(RPN_MSG_TYPE_LAST));

   // The bridge handshake always follows the buffer, even for beats that are
   // discarded, so a full buffer stalls dropped packets as well.
   assign from_network_bridge_tready = buf_in_ready;
   assign in_fire  = from_network_bridge_tvalid & buf_in_ready;
   assign fwd      = (state == PASS) | ((state == HDR) & hdr_legal);
   assign drop_evt = in_fire & (state == HDR) & ~hdr_legal;

   always_comb begin
      in_beat      = '0;
      in_beat.data = from_network_bridge_tdata;
      in_beat.keep = from_network_bridge_tkeep;
      in_beat.id   = from_network_bridge_tid;
      in_beat.dest = from_network_bridge_tdest;
      in_beat.user = from_network_bridge_tuser;
      in_beat.last = from_network_bridge_tlast;
   end

   rpn_wnn_axis_skid_buffer #(
      .WIDTH (AXIS_NB_BEAT_WIDTH)
   ) u_skid (
      .i_clk      (i_clk),
      .i_ap_rst_n (i_ap_rst_n),
      .in_valid   (from_network_bridge_tvalid & fwd),
      .in_ready   (buf_in_ready),
      .in_data    (in_beat),
      .out_valid  (buf_out_valid),
      .out_ready  (to_splitter_tready),
      .out_data   (out_beat)
   );

   assign to_splitter_tvalid = buf_out_valid;
   assign to_splitter_tdata  = out_beat.data;
   assign to_splitter_tkeep  = out_beat.keep;
   assign to_splitter_tid    = out_beat.id;
   assign to_splitter_tdest  = out_beat.dest;
   assign to_splitter_tuser  = out_beat.user;
   assign to_splitter_tlast  = out_beat.last;

   always_ff @(posedge i_clk) begin
      if (!i_ap_rst_n) begin
         state        <= HDR;
         drop_pulse_q <= 1'b0;
      end else begin
         drop_pulse_q <= drop_evt;
         if (in_fire) begin
            case (state)
               HDR: begin
                  // A single-beat packet is fully handled here.
                  if (!from_network_bridge_tlast) begin
                     state <= hdr_legal ? PASS : DROP;
                  end
               end
               PASS, DROP: begin
                  if (from_network_bridge_tlast) begin
                     state <= HDR;
                  end
               end
               default: state <= HDR;
            endcase
         end
      end
   end

   assign o_drop_pulse = drop_pulse_q;

`ifdef RPN_WNN_INGRESS_DROP_CNT_EN
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q;

   // Updates on the same edge that raises o_drop_pulse.
   always_ff @(posedge i_clk) begin
      if (!i_ap_rst_n) begin
         drop_cnt_q <= '0;
      end else if (drop_evt && (drop_cnt_q != '1)) begin
         drop_cnt_q <= drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
   end

   assign o_drop_cnt = drop_cnt_q;
`else
   assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rpn_wnn_from_network_bridge_ingress.sv
// ---------------------------------------------------------------------------
// tb_rpn_wnn_from_network_bridge_ingress
// Directed, table-driven bench for the WNN network-bridge ingress stage.
// A second instance with a 2-bit drop counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_rpn_wnn_from_network_bridge_ingress;
   import rpn_wnn_pkg::*;

`ifdef RPN_WNN_INGRESS_DROP_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // stimulus side
   axis_nb_beat_t drv;
   logic          drv_valid;
   logic          from_tready;
   logic          hold_rdy;
   logic          tog_en;
   logic          tog_q = 1'b0;
   logic          to_tready;

   // DUT outputs
   logic                                to_tvalid;
   logic [AXIS_DATA_WIDTH-1:0]          to_tdata;
   logic [AXIS_KEEP_WIDTH-1:0]          to_tkeep;
   logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_tid;
   logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_tdest;
   logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_tuser;
   logic                                to_tlast;
   logic                                drop_pulse;
   logic [15:0]                         drop_cnt;
   axis_nb_beat_t                       mon;

   // saturation instance outputs
   logic                                s_from_tready;
   logic                                s_tvalid;
   logic [AXIS_DATA_WIDTH-1:0]          s_tdata;
   logic [AXIS_KEEP_WIDTH-1:0]          s_tkeep;
   logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] s_tid;
   logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] s_tdest;
   logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] s_tuser;
   logic                                s_tlast;
   logic                                s_pulse;
   logic [1:0]                          s_cnt;

   assign to_tready = tog_en ? tog_q : hold_rdy;
   assign mon = '{data: to_tdata, keep: to_tkeep, id: to_tid, dest: to_tdest,
                  user: to_tuser, last: to_tlast};

   rpn_wnn_from_network_bridge_ingress dut (
      .i_clk                      (clk),
      .i_ap_rst_n                 (rst_n),
      .from_network_bridge_tvalid (drv_valid),
      .from_network_bridge_tready (from_tready),
      .from_network_bridge_tdata  (drv.data),
      .from_network_bridge_tkeep  (drv.keep),
      .from_network_bridge_tid    (drv.id),
      .from_network_bridge_tdest  (drv.dest),
      .from_network_bridge_tuser  (drv.user),
      .from_network_bridge_tlast  (drv.last),
      .to_splitter_tvalid         (to_tvalid),
      .to_splitter_tready         (to_tready),
      .to_splitter_tdata          (to_tdata),
      .to_splitter_tkeep          (to_tkeep),
      .to_splitter_tid            (to_tid),
      .to_splitter_tdest          (to_tdest),
      .to_splitter_tuser          (to_tuser),
      .to_splitter_tlast          (to_tlast),
      .o_drop_pulse               (drop_pulse),
      .o_drop_cnt                 (drop_cnt)
   );

   rpn_wnn_from_network_bridge_ingress #(.DROP_CNT_WIDTH(2)) u_sat (
      .i_clk                      (clk),
      .i_ap_rst_n                 (rst_n),
      .from_network_bridge_tvalid (drv_valid),
      .from_network_bridge_tready (s_from_tready),
      .from_network_bridge_tdata  (drv.data),
      .from_network_bridge_tkeep  (drv.keep),
      .from_network_bridge_tid    (drv.id),
      .from_network_bridge_tdest  (drv.dest),
      .from_network_bridge_tuser  (drv.user),
      .from_network_bridge_tlast  (drv.last),
      .to_splitter_tvalid         (s_tvalid),
      .to_splitter_tready         (1'b1),
      .to_splitter_tdata          (s_tdata),
      .to_splitter_tkeep          (s_tkeep),
      .to_splitter_tid            (s_tid),
      .to_splitter_tdest          (s_tdest),
      .to_splitter_tuser          (s_tuser),
      .to_splitter_tlast          (s_tlast),
      .o_drop_pulse               (s_pulse),
      .o_drop_cnt                 (s_cnt)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int pulse_cycles = 0;
   logic [7:0] tag_ctr = 8'h10;

   axis_nb_beat_t exp_q[$];
   axis_nb_beat_t rx_q[$];
   int            rx_cyc[$];

   typedef struct {
      logic [7:0] typ;
      logic       last;
      logic       fwd;
   } vec_t;
   vec_t tbl[18];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_beat(input string name, input axis_nb_beat_t act, input axis_nb_beat_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got data[63:0]=0x%0h user=0x%0h last=%0b, expected data[63:0]=0x%0h user=0x%0h last=%0b",
                  name, act.data[63:0], act.user, act.last, exp.data[63:0], exp.user, exp.last);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      if (tog_en) tog_q = ~tog_q;
   end

   // Output monitor: records every handshake and checks AXIS hold rules.
   logic          stall_prev = 1'b0;
   axis_nb_beat_t held;
   always @(negedge clk) begin
      if (rst_n && stall_prev) begin
         chk("hold_valid", 64'(to_tvalid), 64'd1);
         chk_beat("hold_payload", mon, held);
      end
      stall_prev = rst_n & to_tvalid & ~to_tready;
      held       = mon;
      if (rst_n && to_tvalid && to_tready) begin
         rx_q.push_back(mon);
         rx_cyc.push_back(cyc);
      end
      if (rst_n && drop_pulse) pulse_cycles++;
   end

   function automatic axis_nb_beat_t mk_beat(input logic [7:0] tag, input logic [7:0] typ,
                                             input logic last);
      axis_nb_beat_t b;
      for (int k = 0; k < 16; k++)
         b.data[k*32 +: 32] = {tag, 8'(k), 8'h5A, tag ^ 8'(k)};
      b.data[7:0] = typ;
      b.keep = {8{tag}};
      b.id   = {8'hD1, tag};
      b.dest = {8'hE2, tag};
      b.user = {8'hF3, ~tag};
      b.last = last;
      return b;
   endfunction

   task automatic send(input axis_nb_beat_t b);
      logic r;
      bit   ok;
      ok = 1'b0;
      drv = b;
      drv_valid = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         r = from_tready;
         @(posedge clk);
         #1;
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
      drv_valid = 1'b0;
      chk("send_accepted", 64'(ok), 64'd1);
   endtask

   task automatic send_new(input logic [7:0] typ, input logic last, input logic fwd);
      axis_nb_beat_t b;
      b = mk_beat(tag_ctr, typ, last);
      tag_ctr++;
      send(b);
      if (fwd) exp_q.push_back(b);
   endtask

   task automatic run_seg(input int lo, input int hi);
      axis_nb_beat_t b;
      for (int i = lo; i <= hi; i++) begin
         b = mk_beat(tag_ctr, tbl[i].typ, tbl[i].last);
         tag_ctr++;
         send(b);
         if (tbl[i].fwd) exp_q.push_back(b);
         if (i == 0) begin
            chk("latency_valid", 64'(to_tvalid), 64'd1);
            chk_beat("latency_payload", mon, b);
         end
      end
   endtask

   task automatic drain_cmp(input string name);
      int n;
      repeat (8) @(posedge clk);
      #1;
      chk({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk_beat({name, "_beat"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_tvalid", 64'(to_tvalid), 64'd0);
      chk("rst_in_tready", 64'(from_tready), 64'd0);
      chk("rst_pulse", 64'(drop_pulse), 64'd0);
      chk("rst_cnt", 64'(drop_cnt), 64'd0);
      chk("rst_tdata", to_tdata[63:0], 64'd0);
      rx_q.delete();
      rx_cyc.delete();
      exp_q.delete();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      int p0;
      int exp_sat[5];
      exp_sat = '{1, 2, 3, 3, 3};

      for (int i = 0; i < 8; i++) tbl[i] = '{typ: 8'(i), last: 1'b1, fwd: 1'b1};
      tbl[8]  = '{typ: 8'd8,   last: 1'b0, fwd: 1'b0};
      tbl[9]  = '{typ: 8'd1,   last: 1'b0, fwd: 1'b0};
      tbl[10] = '{typ: 8'd1,   last: 1'b1, fwd: 1'b0};
      tbl[11] = '{typ: 8'd2,   last: 1'b0, fwd: 1'b1};
      tbl[12] = '{typ: 8'hFF,  last: 1'b1, fwd: 1'b1};
      tbl[13] = '{typ: 8'd5,   last: 1'b0, fwd: 1'b1};
      tbl[14] = '{typ: 8'hFF,  last: 1'b0, fwd: 1'b1};
      tbl[15] = '{typ: 8'hFF,  last: 1'b1, fwd: 1'b1};
      tbl[16] = '{typ: 8'd8,   last: 1'b1, fwd: 1'b0};
      tbl[17] = '{typ: 8'd7,   last: 1'b1, fwd: 1'b1};

      drv       = '0;
      drv_valid = 1'b0;
      hold_rdy  = 1'b1;
      tog_en    = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      do_reset(3);
      @(posedge clk);
      #1;
      chk("in_tready_after_reset", 64'(from_tready), 64'd1);

      // legal single-beat packets, back-to-back
      run_seg(0, 7);
      repeat (4) @(posedge clk);
      #1;
      if (rx_cyc.size() == 8)
         for (int k = 1; k < 8; k++)
            chk("throughput_cycle", 64'(rx_cyc[k] - rx_cyc[0]), 64'(k));
      drain_cmp("legal_1beat");

      // illegal 3-beat packet followed by legal 2-beat packet
      p0 = pulse_cycles;
      run_seg(8, 12);
      drain_cmp("drop_then_pass");
      chk("drop_pulse_cycles", 64'(pulse_cycles - p0), 64'd1);
      chk("drop_cnt_1", 64'(drop_cnt), CNT_ON ? 64'd1 : 64'd0);

      // later beats with low byte 0xFF, plus single-beat boundary types
      p0 = pulse_cycles;
      run_seg(13, 17);
      drain_cmp("type_hdr_only");
      chk("drop_pulse_single", 64'(pulse_cycles - p0), 64'd1);
      chk("drop_cnt_2", 64'(drop_cnt), CNT_ON ? 64'd2 : 64'd0);

      // downstream stall then 1010 toggling, 4-beat type-3 packet
      hold_rdy = 1'b0;
      send_new(8'd3, 1'b0, 1'b1);
      send_new(8'd3, 1'b0, 1'b1);
      chk("stall_in_tready", 64'(from_tready), 64'd0);
      chk("stall_out_tvalid", 64'(to_tvalid), 64'd1);
      tog_en = 1'b1;
      send_new(8'd3, 1'b0, 1'b1);
      send_new(8'd3, 1'b1, 1'b1);
      drain_cmp("toggle_ready");
      tog_en   = 1'b0;
      hold_rdy = 1'b1;

      // reset in the middle of a legal packet
      send_new(8'd4, 1'b0, 1'b1);
      send_new(8'd4, 1'b0, 1'b1);
      drain_cmp("pre_reset");
      do_reset(2);
      p0 = pulse_cycles;
      send_new(8'd200, 1'b1, 1'b0);
      send_new(8'd1, 1'b0, 1'b1);
      send_new(8'd1, 1'b1, 1'b1);
      drain_cmp("post_reset");
      chk("post_reset_pulse", 64'(pulse_cycles - p0), 64'd1);

      // 2-bit counter saturation
      do_reset(2);
      for (int i = 0; i < 5; i++) begin
         send_new(8'(8 + i), 1'b1, 1'b0);
         chk("sat_cnt", 64'(s_cnt), CNT_ON ? 64'(exp_sat[i]) : 64'd0);
      end
      drain_cmp("sat_no_output");
      chk("drop_cnt_5", 64'(drop_cnt), CNT_ON ? 64'd5 : 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
